// File: rtl/mem_pkg.sv
// Shared definitions for the load/store sequencer: access sizes, FSM states,
// and the big-endian lane extract/merge helpers.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_RD,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Byte offset 0 is the most significant byte, so lane shifts count down from 24.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  offset,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [31:0] res;
    logic [4:0]  sh;
    res = word;
    sh  = 5'd0;
    case (size)
      SZ_BYTE: begin
        sh  = {~offset, 3'b000};
        res = (word >> sh) & 32'h0000_00FF;
        if (!uns && res[7]) res = res | 32'hFFFF_FF00;
      end
      SZ_HALF: begin
        sh  = {~offset[1], 4'b0000};
        res = (word >> sh) & 32'h0000_FFFF;
        if (!uns && res[15]) res = res | 32'hFFFF_0000;
      end
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  offset,
                                             input logic [1:0]  size);
    logic [31:0] mask;
    logic [4:0]  sh;
    logic [31:0] res;
    res  = wdata;
    mask = 32'd0;
    sh   = 5'd0;
    case (size)
      SZ_BYTE: begin
        sh   = {~offset, 3'b000};
        mask = 32'h0000_00FF << sh;
        res  = (old & ~mask) | ((wdata & 32'h0000_00FF) << sh);
      end
      SZ_HALF: begin
        sh   = {~offset[1], 4'b0000};
        mask = 32'h0000_FFFF << sh;
        res  = (old & ~mask) | ((wdata & 32'h0000_FFFF) << sh);
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane handling: extended load result and read-modify-write
// merge for the word currently addressed in dm.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] ext_data,
  output logic [31:0] merged
);

  assign ext_data = lane_extract(rdata, offset, size, uns);
  assign merged   = lane_merge(rdata, wdata, offset, size);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between execute and the word-addressed data memory.
// One access in flight; sub-word stores go through a read-modify-write.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        dm_we,
  output logic [31:0] dm_a,
  output logic [31:0] dm_wd,
  input  logic [31:0] dm_rd,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_wen,
  output logic        err_misalign,
  output logic        err_range
);

  state_t state, state_nx;

  logic [ADDR_BITS+1:0] rq_addr;
  logic [1:0]           rq_size;
  logic                 rq_uns;
  logic [31:0]          rq_wdata;
  logic [4:0]           rq_rd;
  logic [31:0]          hold;
  logic                 err_pend, err_mis_q, err_rng_q;

  logic        accept, mis_in, rng_in, bad_in;
  logic [1:0]  size_in;
  logic [31:0] ext_data, merged;

  // Reserved size encoding behaves exactly like a word access.
  assign size_in = (req_size == 2'b11) ? SZ_WORD : req_size;
  assign accept  = req_valid && (state == ST_IDLE);
  assign mis_in  = ((size_in == SZ_HALF) && req_addr[0]) ||
                   ((size_in == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign rng_in  = (req_addr[31:ADDR_BITS+2] != '0);
  assign bad_in  = mis_in || rng_in;

  assign dm_a = {{(32-ADDR_BITS){1'b0}}, rq_addr[ADDR_BITS+1:2]};

  mem_lane_align u_align (
    .rdata    (dm_rd),
    .wdata    (rq_wdata),
    .offset   (rq_addr[1:0]),
    .size     (rq_size),
    .uns      (rq_uns),
    .ext_data (ext_data),
    .merged   (merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    dm_we     = 1'b0;
    dm_wd     = 32'd0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (accept && !bad_in) begin
          if (!req_we)                  state_nx = ST_LOAD;
          else if (size_in == SZ_WORD)  state_nx = ST_WRITE;
          else                          state_nx = ST_RMW_RD;
        end
      end
      ST_LOAD:   state_nx = ST_IDLE;
      ST_RMW_RD: state_nx = ST_WRITE;
      ST_WRITE: begin
        dm_we    = 1'b1;
        dm_wd    = (rq_size == SZ_WORD) ? rq_wdata : hold;
        state_nx = ST_DONE;
      end
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Request capture, merge holding register and the registered response.
  // Errors are delayed one cycle through err_pend so they share the load latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq_addr      <= '0;
      rq_size      <= SZ_BYTE;
      rq_uns       <= 1'b0;
      rq_wdata     <= 32'd0;
      rq_rd        <= 5'd0;
      hold         <= 32'd0;
      err_pend     <= 1'b0;
      err_mis_q    <= 1'b0;
      err_rng_q    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= 32'd0;
      rsp_rd       <= 5'd0;
      rsp_wen      <= 1'b0;
      err_misalign <= 1'b0;
      err_range    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      err_pend  <= accept && bad_in;
      if (accept) begin
        rq_addr   <= req_addr[ADDR_BITS+1:0];
        rq_size   <= size_in;
        rq_uns    <= req_unsigned;
        rq_wdata  <= req_wdata;
        rq_rd     <= req_rd;
        err_mis_q <= mis_in;
        err_rng_q <= rng_in;
      end
      if (err_pend) begin
        rsp_valid    <= 1'b1;
        rsp_data     <= 32'd0;
        rsp_rd       <= rq_rd;
        rsp_wen      <= 1'b0;
        err_misalign <= err_mis_q;
        err_range    <= err_rng_q;
      end
      case (state)
        ST_LOAD: begin
          rsp_valid    <= 1'b1;
          rsp_data     <= ext_data;
          rsp_rd       <= rq_rd;
          rsp_wen      <= 1'b1;
          err_misalign <= 1'b0;
          err_range    <= 1'b0;
        end
        ST_RMW_RD: hold <= merged;
        ST_DONE: begin
          rsp_valid    <= 1'b1;
          rsp_data     <= 32'd0;
          rsp_rd       <= rq_rd;
          rsp_wen      <= 1'b0;
          err_misalign <= 1'b0;
          err_range    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized traffic checked
// against a byte-array memory model with a timed queue of expected responses.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        dm_we;
  logic [31:0] dm_a, dm_wd, dm_rd;
  logic        rsp_valid, rsp_wen, err_misalign, err_range;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;

  logic [31:0] dm [32];
  assign dm_rd = dm[dm_a[4:0]];

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_BITS(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .dm_we(dm_we), .dm_a(dm_a), .dm_wd(dm_wd), .dm_rd(dm_rd),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .rsp_wen(rsp_wen), .err_misalign(err_misalign), .err_range(err_range)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        wen;
    logic [4:0]  rd;
    logic        mis;
    logic        rng;
  } exp_t;

  int tests = 0, fails = 0;
  int cyc = 0, acc_cyc = 0;
  bit chk_en = 0;
  int rsp_count = 0, we_pulses = 0, last_rsp_cyc = 0;
  logic [31:0] last_data;
  logic        last_wen, last_mis, last_rng;
  logic [4:0]  last_rd;

  logic [7:0]  ref_bytes [128];
  exp_t        exp_q [$];
  int          busy_until = 0, we_due = -1;
  logic [31:0] exp_wd, exp_idx;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] refWord(input int i);
    return {ref_bytes[4*i], ref_bytes[4*i+1], ref_bytes[4*i+2], ref_bytes[4*i+3]};
  endfunction

  // Reference: memory is a flat big-endian byte array; timing comes from fixed latencies.
  task automatic modelAccept();
    exp_t        e;
    int          nbytes, lat, ai;
    logic [31:0] v;
    nbytes = (req_size == 2'b11) ? 4 : (1 << req_size);
    e.rd   = req_rd;
    e.mis  = (req_addr & 32'(nbytes - 1)) != 32'd0;
    e.rng  = req_addr >= 32'd128;
    e.data = 32'd0;
    e.wen  = 1'b0;
    if (e.mis || e.rng) begin
      e.due      = cyc + 2;
      busy_until = cyc + 1;
    end else if (!req_we) begin
      ai = int'(req_addr);
      v  = 32'd0;
      for (int k = 0; k < nbytes; k++) v = (v << 8) | 32'(ref_bytes[ai + k]);
      if (!req_unsigned && nbytes < 4 && v[8*nbytes-1]) v = v - (32'd1 << (8*nbytes));
      e.data     = v;
      e.wen      = 1'b1;
      e.due      = cyc + 2;
      busy_until = cyc + 2;
    end else begin
      ai = int'(req_addr);
      for (int k = 0; k < nbytes; k++) ref_bytes[ai + k] = 8'(req_wdata >> (8*(nbytes - 1 - k)));
      lat        = (nbytes == 4) ? 2 : 3;
      e.due      = cyc + 1 + lat;
      busy_until = cyc + 1 + lat;
      we_due     = cyc + lat - 1;
      exp_idx    = 32'(ai / 4);
      exp_wd     = refWord(ai / 4);
    end
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    bit   due;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        rsp_count++;
        last_data = rsp_data; last_wen = rsp_wen; last_rd = rsp_rd;
        last_mis = err_misalign; last_rng = err_range; last_rsp_cyc = cyc;
      end
      if (dm_we) we_pulses++;
      if (!chk_en) begin
        exp_q.delete();
        busy_until = 0;
        we_due = -1;
        continue;
      end
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        tests++; fails++;
        $display("[TB] FAIL rsp_missing: response due at cycle %0d absent, now %0d", exp_q[0].due, cyc);
        void'(exp_q.pop_front());
      end
      due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(due));
      if (due) begin
        e = exp_q.pop_front();
        if (rsp_valid) begin
          checkOutput("rsp_data", rsp_data, e.data);
          checkOutput("rsp_wen", 32'(rsp_wen), 32'(e.wen));
          checkOutput("rsp_rd", 32'(rsp_rd), 32'(e.rd));
          checkOutput("err_misalign", 32'(err_misalign), 32'(e.mis));
          checkOutput("err_range", 32'(err_range), 32'(e.rng));
        end
      end
      checkOutput("req_ready", 32'(req_ready), 32'(cyc >= busy_until));
      checkOutput("dm_we", 32'(dm_we), 32'(cyc == we_due));
      if (dm_we && cyc == we_due) begin
        checkOutput("dm_a", dm_a, exp_idx);
        checkOutput("dm_wd", dm_wd, exp_wd);
      end
      if (req_valid && req_ready) modelAccept();
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      tests++; fails++;
      $display("[TB] FAIL accept_timeout: req_ready %b, expected 1", req_ready);
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
  endtask

  task automatic idleReq();
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
  endtask

  task automatic waitRsp(input int target);
    int n = 0;
    while (rsp_count < target && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (rsp_count < target) begin
      tests++; fails++;
      $display("[TB] FAIL rsp_timeout: got %0d responses, expected %0d", rsp_count, target);
    end
  endtask

  initial begin
    int rc, wp, r;
    logic [31:0] a;
    for (int i = 0; i < 32; i++) dm[i] = $urandom;
    dm[10] = 32'h55AA_55AA;
    dm[11] = 32'h7788_7788;
    for (int i = 0; i < 32; i++)
      for (int k = 0; k < 4; k++) ref_bytes[4*i+k] = 8'(dm[i] >> (8*(3-k)));
    rst = 1'b1;
    idleReq();

    fork
      monitor();
      forever begin
        @(posedge clk);
        cyc <= cyc + 1;
        if (dm_we) dm[dm_a[4:0]] <= dm_wd;
      end
      begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
      end
    join_none

    #2;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_dm_we", 32'(dm_we), 32'd0);
    checkOutput("rst_dm_a", dm_a, 32'd0);
    checkOutput("rst_dm_wd", dm_wd, 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", rsp_data, 32'd0);
    checkOutput("rst_rsp_rd", 32'(rsp_rd), 32'd0);
    checkOutput("rst_rsp_wen", 32'(rsp_wen), 32'd0);
    checkOutput("rst_err_misalign", 32'(err_misalign), 32'd0);
    checkOutput("rst_err_range", 32'(err_range), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1;

    rc = rsp_count;
    applyStimulus(1'b0, SZ_BYTE, 1'b0, 32'h29, $urandom, 5'd3);
    idleReq();
    waitRsp(rc + 1);
    checkOutput("lb_data", last_data, 32'hFFFF_FFAA);
    checkOutput("lb_wen", 32'(last_wen), 32'd1);
    checkOutput("lb_rd", 32'(last_rd), 32'd3);
    checkOutput("lb_latency", 32'(last_rsp_cyc - acc_cyc), 32'd1);

    rc = rsp_count;
    applyStimulus(1'b0, SZ_BYTE, 1'b1, 32'h29, $urandom, 5'd7);
    idleReq();
    waitRsp(rc + 1);
    checkOutput("lbu_data", last_data, 32'h0000_00AA);
    checkOutput("lbu_rd", 32'(last_rd), 32'd7);

    rc = rsp_count;
    applyStimulus(1'b0, SZ_HALF, 1'b0, 32'h2A, $urandom, 5'd9);
    idleReq();
    waitRsp(rc + 1);
    checkOutput("lh_data", last_data, 32'h0000_55AA);
    checkOutput("lh_latency", 32'(last_rsp_cyc - acc_cyc), 32'd1);

    chk_en = 0;
    rc = rsp_count;
    wp = we_pulses;
    applyStimulus(1'b1, SZ_HALF, 1'b0, 32'h2C, 32'h0000_BEEF, 5'd1);
    idleReq();
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
    checkOutput("abort_dm_we", 32'(dm_we), 32'd0);
    checkOutput("abort_dm_a", dm_a, 32'd0);
    checkOutput("abort_dm_wd", dm_wd, 32'd0);
    checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("abort_mem11", dm[11], 32'h7788_7788);
    checkOutput("abort_no_rsp", 32'(rsp_count - rc), 32'd0);
    checkOutput("abort_no_write", 32'(we_pulses - wp), 32'd0);
    chk_en = 1;

    rc = rsp_count;
    wp = we_pulses;
    applyStimulus(1'b1, SZ_BYTE, 1'b0, 32'h2D, 32'h0000_0012, 5'd2);
    idleReq();
    waitRsp(rc + 1);
    checkOutput("sb_mem11", dm[11], 32'h7712_7788);
    checkOutput("sb_we_pulses", 32'(we_pulses - wp), 32'd1);
    checkOutput("sb_latency", 32'(last_rsp_cyc - acc_cyc), 32'd3);
    checkOutput("sb_wen", 32'(last_wen), 32'd0);

    rc = rsp_count;
    applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h08, 32'hDEAD_BEEF, 5'd4);
    idleReq();
    waitRsp(rc + 1);
    checkOutput("sw_latency", 32'(last_rsp_cyc - acc_cyc), 32'd2);
    rc = rsp_count;
    applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h08, $urandom, 5'd5);
    idleReq();
    waitRsp(rc + 1);
    checkOutput("lw_data", last_data, 32'hDEAD_BEEF);

    rc = rsp_count;
    wp = we_pulses;
    applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h2A, $urandom, 5'd6);
    idleReq();
    waitRsp(rc + 1);
    checkOutput("mis_flag", 32'(last_mis), 32'd1);
    checkOutput("mis_wen", 32'(last_wen), 32'd0);
    checkOutput("mis_data", last_data, 32'd0);
    checkOutput("mis_latency", 32'(last_rsp_cyc - acc_cyc), 32'd1);
    rc = rsp_count;
    applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h80, $urandom, 5'd8);
    idleReq();
    waitRsp(rc + 1);
    checkOutput("rng_flag", 32'(last_rng), 32'd1);
    checkOutput("rng_mis", 32'(last_mis), 32'd0);
    checkOutput("err_no_write", 32'(we_pulses - wp), 32'd0);

    rc = rsp_count;
    applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h28, $urandom, 5'd10);
    applyStimulus(1'b1, SZ_BYTE, 1'b0, 32'h31, 32'h0000_00C3, 5'd11);
    applyStimulus(1'b0, SZ_HALF, 1'b1, 32'h2E, $urandom, 5'd12);
    applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h40, 32'h1234_5678, 5'd13);
    idleReq();
    waitRsp(rc + 4);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("b2b_count", 32'(rsp_count - rc), 32'd4);
    checkOutput("b2b_last_rd", 32'(last_rd), 32'd13);

    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 15));
      a = (r == 0) ? $urandom : 32'($urandom_range(0, 127));
      applyStimulus(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 5'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        idleReq();
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
    end
    idleReq();
    repeat (8) @(posedge clk);
    #1;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 32; i++) checkOutput($sformatf("mem_word%0d", i), dm[i], refWord(i));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
